// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, source indices and helpers for the common-data-bus arbiter.
// Every file that needs these imports the package.
package cdb_arbiter_pkg;

    localparam int ROBIdxWidth = 5;
    localparam int WordWidth   = 32;
    localparam int AddrWidth   = 32;

    localparam int CDBNumSrc   = 3;
    localparam int CDBSrcWidth = 2;
    localparam int SRC_ALU     = 0;
    localparam int SRC_BR      = 1;
    localparam int SRC_LSB     = 2;

    // One result as it appears on the bus, tagged with its source.
    typedef struct packed {
        logic [CDBSrcWidth-1:0] src;
        logic [ROBIdxWidth-1:0] robPos;
        logic [WordWidth-1:0]   res;
        logic                   jumpEn;
        logic [AddrWidth-1:0]   jumpA;
    } cdb_beat_t;

    // Next index in the round-robin ring of numSrc sources.
    function automatic logic [CDBSrcWidth-1:0] wrapInc(input logic [CDBSrcWidth-1:0] idx,
                                                       input int numSrc);
        if (int'(idx) >= numSrc - 1) begin
            return '0;
        end
        return idx + CDBSrcWidth'(1);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Source handshake and CDB bundle. The arbiter uses the slave modport;
// the completing units and the CDB consumers sit on the master side.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = CDBNumSrc,
    parameter int ROB_IDX_W = ROBIdxWidth,
    parameter int WORD_W    = WordWidth,
    parameter int ADDR_W    = AddrWidth
);

    logic                          rdy_in;
    logic                          clear_branch_in;

    logic [NUM_SRC-1:0]            src_valid_in;
    logic [NUM_SRC-1:0]            src_ready_out;
    logic [NUM_SRC*ROB_IDX_W-1:0]  src_rob_pos_in;
    logic [NUM_SRC*WORD_W-1:0]     src_res_in;
    logic [NUM_SRC-1:0]            src_jump_en_in;
    logic [NUM_SRC*ADDR_W-1:0]     src_jump_a_in;

    logic                          cdb_en_out;
    logic [CDBSrcWidth-1:0]        cdb_src_out;
    logic [ROB_IDX_W-1:0]          cdb_rob_pos_out;
    logic [WORD_W-1:0]             cdb_res_out;
    logic                          cdb_jump_en_out;
    logic [ADDR_W-1:0]             cdb_jump_a_out;

    modport master (
        output rdy_in, clear_branch_in,
        output src_valid_in, src_rob_pos_in, src_res_in, src_jump_en_in, src_jump_a_in,
        input  src_ready_out,
        input  cdb_en_out, cdb_src_out, cdb_rob_pos_out, cdb_res_out,
        input  cdb_jump_en_out, cdb_jump_a_out
    );

    modport slave (
        input  rdy_in, clear_branch_in,
        input  src_valid_in, src_rob_pos_in, src_res_in, src_jump_en_in, src_jump_a_in,
        output src_ready_out,
        output cdb_en_out, cdb_src_out, cdb_rob_pos_out, cdb_res_out,
        output cdb_jump_en_out, cdb_jump_a_out
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotate-priority picker: the first requester at or after the
// pointer (wrapping) wins.
module cdb_rr_pick #(
    parameter int NUM_SRC = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_SRC-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    // Scan farthest-to-nearest so the position closest to the pointer is written last.
    always_comb begin
        int pos;
        logic [PTR_W-1:0] posIdx;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = 0;
        posIdx  = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_SRC) begin
                pos = pos - NUM_SRC;
            end
            posIdx = PTR_W'(pos);
            if (req_i[posIdx]) begin
                grant_o         = '0;
                grant_o[posIdx] = 1'b1;
                idx_o           = posIdx;
                any_o           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the single ROB result-write port among the completing units: one
// hold buffer per source, round-robin grant, registered CDB outputs.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = CDBNumSrc,
    parameter int ROB_IDX_W = ROBIdxWidth,
    parameter int WORD_W    = WordWidth,
    parameter int ADDR_W    = AddrWidth
) (
    input logic          clk_in,
    input logic          rst_n_in,
    cdb_arbiter_if.slave bus
);

    logic [NUM_SRC-1:0]     bufValid_q;
    logic [NUM_SRC-1:0]     bufValid_d;
    logic [ROB_IDX_W-1:0]   bufRobPos_q [NUM_SRC];
    logic [WORD_W-1:0]      bufRes_q    [NUM_SRC];
    logic [NUM_SRC-1:0]     bufJumpEn_q;
    logic [ADDR_W-1:0]      bufJumpA_q  [NUM_SRC];
    logic [CDBSrcWidth-1:0] rrPtr_q;
    logic [CDBSrcWidth-1:0] rrPtr_d;

    logic                   cdbEn_q;
    logic [CDBSrcWidth-1:0] cdbSrc_q;
    logic [ROB_IDX_W-1:0]   cdbRobPos_q;
    logic [WORD_W-1:0]      cdbRes_q;
    logic                   cdbJumpEn_q;
    logic [ADDR_W-1:0]      cdbJumpA_q;

    logic [NUM_SRC-1:0]     grant;
    logic [CDBSrcWidth-1:0] winIdx;
    logic                   anyGrant;
    logic                   active;
    logic [NUM_SRC-1:0]     srcReady;
    logic [NUM_SRC-1:0]     accept;

    cdb_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .PTR_W   (CDBSrcWidth)
    ) uPick (
        .req_i   (bufValid_q),
        .ptr_i   (rrPtr_q),
        .grant_o (grant),
        .idx_o   (winIdx),
        .any_o   (anyGrant)
    );

    // A buffer being granted this edge can be refilled on the same edge.
    assign active     = bus.rdy_in && !bus.clear_branch_in;
    assign srcReady   = active ? (~bufValid_q | grant) : '0;
    assign accept     = srcReady & bus.src_valid_in;
    assign bufValid_d = (bufValid_q & ~grant) | accept;
    assign rrPtr_d    = anyGrant ? wrapInc(winIdx, NUM_SRC) : rrPtr_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            bufValid_q  <= '0;
            rrPtr_q     <= '0;
            cdbEn_q     <= 1'b0;
            cdbSrc_q    <= '0;
            cdbRobPos_q <= '0;
            cdbRes_q    <= '0;
            cdbJumpEn_q <= 1'b0;
            cdbJumpA_q  <= '0;
        end else if (bus.rdy_in) begin
            if (bus.clear_branch_in) begin
                bufValid_q <= '0;
                rrPtr_q    <= '0;
                cdbEn_q    <= 1'b0;
            end else begin
                bufValid_q <= bufValid_d;
                rrPtr_q    <= rrPtr_d;
                cdbEn_q    <= anyGrant;
                if (anyGrant) begin
                    cdbSrc_q    <= winIdx;
                    cdbRobPos_q <= bufRobPos_q[winIdx];
                    cdbRes_q    <= bufRes_q[winIdx];
                    cdbJumpEn_q <= bufJumpEn_q[winIdx];
                    cdbJumpA_q  <= bufJumpA_q[winIdx];
                end
            end
        end
    end

    // Payload storage needs no reset; it is only read while its valid bit is set.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (accept[i]) begin
                bufRobPos_q[i] <= bus.src_rob_pos_in[i*ROB_IDX_W +: ROB_IDX_W];
                bufRes_q[i]    <= bus.src_res_in[i*WORD_W +: WORD_W];
                bufJumpEn_q[i] <= bus.src_jump_en_in[i];
                bufJumpA_q[i]  <= bus.src_jump_a_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign bus.src_ready_out   = srcReady;
    assign bus.cdb_en_out      = cdbEn_q;
    assign bus.cdb_src_out     = cdbSrc_q;
    assign bus.cdb_rob_pos_out = cdbRobPos_q;
    assign bus.cdb_res_out     = cdbRes_q;
    assign bus.cdb_jump_en_out = cdbJumpEn_q;
    assign bus.cdb_jump_a_out  = cdbJumpA_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues the expected CDB beats,
// a negedge monitor pops and compares each new bus output.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rstN;
    int   testsRun    = 0;
    int   testsFailed = 0;
    logic edgeActive  = 1'b0;
    cdb_beat_t expQ[$];

    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk_in   (clk),
        .rst_n_in (rstN),
        .bus      (bus)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setSrc(input int i, input int pos, input logic [31:0] res,
                          input logic je, input logic [31:0] ja);
        bus.src_rob_pos_in[i*ROBIdxWidth +: ROBIdxWidth] = ROBIdxWidth'(pos);
        bus.src_res_in[i*WordWidth +: WordWidth]         = res;
        bus.src_jump_en_in[i]                            = je;
        bus.src_jump_a_in[i*AddrWidth +: AddrWidth]      = ja;
    endtask

    task automatic applyStimulus(input logic [2:0] valid);
        bus.src_valid_in = valid;
    endtask

    task automatic expectBeat(input int src, input int pos, input logic [31:0] res,
                              input logic je, input logic [31:0] ja);
        cdb_beat_t b;
        b.src    = CDBSrcWidth'(src);
        b.robPos = ROBIdxWidth'(pos);
        b.res    = res;
        b.jumpEn = je;
        b.jumpA  = ja;
        expQ.push_back(b);
    endtask

    function automatic logic [127:0] cdbAll();
        return {55'd0, bus.cdb_en_out, bus.cdb_src_out, bus.cdb_rob_pos_out,
                bus.cdb_res_out, bus.cdb_jump_en_out, bus.cdb_jump_a_out};
    endfunction

    // An edge only produces a fresh beat if it was out of reset, enabled and not flushing.
    always @(posedge clk) begin
        edgeActive = rstN && bus.rdy_in && !bus.clear_branch_in;
    end

    always @(negedge clk) begin
        cdb_beat_t obs;
        cdb_beat_t exp;
        if (edgeActive && bus.cdb_en_out) begin
            obs.src    = bus.cdb_src_out;
            obs.robPos = bus.cdb_rob_pos_out;
            obs.res    = bus.cdb_res_out;
            obs.jumpEn = bus.cdb_jump_en_out;
            obs.jumpA  = bus.cdb_jump_a_out;
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_cdb: got %0h, expected no output", obs);
            end else begin
                exp = expQ.pop_front();
                checkOutput("cdb_beat", 128'(obs), 128'(exp));
            end
        end
    end

    initial begin
        rstN                = 1'b0;
        bus.rdy_in          = 1'b1;
        bus.clear_branch_in = 1'b0;
        bus.src_valid_in    = '0;
        bus.src_rob_pos_in  = '0;
        bus.src_res_in      = '0;
        bus.src_jump_en_in  = '0;
        bus.src_jump_a_in   = '0;

        // Reset then idle
        tick();
        tick();
        rstN = 1'b1;
        tick();
        checkOutput("reset_cdb", cdbAll(), 128'd0);
        checkOutput("reset_ready", 128'(bus.src_ready_out), 128'(3'b111));

        // Single ALU result
        setSrc(SRC_ALU, 5, 32'hDEADBEEF, 1'b0, 32'h0);
        expectBeat(SRC_ALU, 5, 32'hDEADBEEF, 1'b0, 32'h0);
        applyStimulus(3'b001);
        tick();
        applyStimulus(3'b000);
        tick();
        tick();
        checkOutput("alu_en_drop", 128'(bus.cdb_en_out), 128'd0);

        // Flush with rr_ptr at 1 puts the pointer back to 0
        bus.clear_branch_in = 1'b1;
        #1;
        checkOutput("flush_ready", 128'(bus.src_ready_out), 128'd0);
        tick();
        bus.clear_branch_in = 1'b0;

        // Three-way contention from rr_ptr 0
        setSrc(SRC_ALU, 1, 32'hA0000001, 1'b0, 32'h0);
        setSrc(SRC_BR,  2, 32'hA0000002, 1'b1, 32'h44);
        setSrc(SRC_LSB, 3, 32'hA0000003, 1'b0, 32'h0);
        expectBeat(SRC_ALU, 1, 32'hA0000001, 1'b0, 32'h0);
        expectBeat(SRC_BR,  2, 32'hA0000002, 1'b1, 32'h44);
        expectBeat(SRC_LSB, 3, 32'hA0000003, 1'b0, 32'h0);
        applyStimulus(3'b111);
        #1;
        checkOutput("contend_ready", 128'(bus.src_ready_out), 128'(3'b111));
        tick();
        applyStimulus(3'b000);
        repeat (3) tick();

        // Lone branch result moves rr_ptr to 2
        setSrc(SRC_BR, 8, 32'hB0000008, 1'b0, 32'h0);
        expectBeat(SRC_BR, 8, 32'hB0000008, 1'b0, 32'h0);
        applyStimulus(3'b010);
        tick();
        applyStimulus(3'b000);
        tick();

        // Three-way contention from rr_ptr 2
        setSrc(SRC_ALU, 1, 32'hC0000001, 1'b0, 32'h0);
        setSrc(SRC_BR,  2, 32'hC0000002, 1'b0, 32'h0);
        setSrc(SRC_LSB, 3, 32'hC0000003, 1'b1, 32'h88);
        expectBeat(SRC_LSB, 3, 32'hC0000003, 1'b1, 32'h88);
        expectBeat(SRC_ALU, 1, 32'hC0000001, 1'b0, 32'h0);
        expectBeat(SRC_BR,  2, 32'hC0000002, 1'b0, 32'h0);
        applyStimulus(3'b111);
        tick();
        applyStimulus(3'b000);
        repeat (3) tick();

        // Back-to-back lone LSB source
        for (int p = 4; p <= 7; p++) begin
            expectBeat(SRC_LSB, p, 32'hD0000000 + 32'(p), 1'b0, 32'h0);
        end
        for (int p = 4; p <= 7; p++) begin
            setSrc(SRC_LSB, p, 32'hD0000000 + 32'(p), 1'b0, 32'h0);
            applyStimulus(3'b100);
            #1;
            checkOutput("lsb_ready", 128'(bus.src_ready_out[SRC_LSB]), 128'd1);
            tick();
        end
        applyStimulus(3'b000);
        tick();
        tick();

        // Flush on the cycle src0 would be granted
        setSrc(SRC_ALU, 6, 32'hE0000006, 1'b0, 32'h0);
        setSrc(SRC_BR,  7, 32'hE0000007, 1'b0, 32'h0);
        applyStimulus(3'b011);
        tick();
        applyStimulus(3'b000);
        bus.clear_branch_in = 1'b1;
        #1;
        checkOutput("flush2_ready", 128'(bus.src_ready_out), 128'd0);
        tick();
        bus.clear_branch_in = 1'b0;
        checkOutput("flush2_en", 128'(bus.cdb_en_out), 128'd0);
        repeat (3) tick();
        checkOutput("flush2_idle", 128'({bus.cdb_en_out, bus.src_ready_out}), 128'(4'b0111));

        // rdy_in stall with a buffered branch result
        setSrc(SRC_BR, 9, 32'hF0000009, 1'b1, 32'h100);
        expectBeat(SRC_BR, 9, 32'hF0000009, 1'b1, 32'h100);
        applyStimulus(3'b010);
        tick();
        applyStimulus(3'b000);
        bus.rdy_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("stall_ready", 128'(bus.src_ready_out), 128'd0);
            checkOutput("stall_hold", 128'({bus.cdb_en_out, bus.cdb_rob_pos_out}),
                        128'({1'b0, 5'd7}));
            tick();
        end
        bus.rdy_in = 1'b1;
        tick();

        // Stall while cdb_en_out is high keeps it high
        bus.rdy_in = 1'b0;
        tick();
        checkOutput("stall_en_hold", 128'({bus.cdb_en_out, bus.cdb_rob_pos_out}),
                    128'({1'b1, 5'd9}));
        bus.rdy_in = 1'b1;
        tick();
        checkOutput("post_stall_en", 128'(bus.cdb_en_out), 128'd0);

        // Mid-operation reset drops a buffered result even with rdy_in low
        setSrc(SRC_ALU, 12, 32'h1234ABCD, 1'b0, 32'h0);
        applyStimulus(3'b001);
        tick();
        applyStimulus(3'b000);
        rstN       = 1'b0;
        bus.rdy_in = 1'b0;
        tick();
        rstN       = 1'b1;
        bus.rdy_in = 1'b1;
        #1;
        checkOutput("midreset_cdb", cdbAll(), 128'd0);
        checkOutput("midreset_ready", 128'(bus.src_ready_out), 128'(3'b111));
        repeat (3) tick();

        checkOutput("drain", 128'(expQ.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single ROB result-write port (common data bus) between several completing units: ALU, branch unit, LSB load path.
- Each source has a one-entry hold buffer with a valid/ready handshake.
- A round-robin scheduler picks one buffered result per cycle and drives it onto a registered CDB. The ROB and reservation stations consume the CDB.
- Branch clear flushes all pending results.

Parameters:
NUM_SRC, 3, number of requesting units (index 0 = ALU, 1 = branch, 2 = LSB load)
ROB_IDX_W, `ROBIdxWidth, ROB position width
WORD_W, `WordWidth, result width
ADDR_W, `AddrWidth, jump target width

Ports:
clk_in  input  1  clock, all state on rising edge
rst_n_in  input  1  synchronous active-low reset
rdy_in  input  1  global enable; low = freeze all state
clear_branch_in  input  1  mispredict flush
src_valid_in  input  NUM_SRC  per-source result valid
src_ready_out  output  NUM_SRC  per-source accept
src_rob_pos_in  input  NUM_SRC*ROB_IDX_W  flattened ROB positions; source i occupies bits [i*ROB_IDX_W +: ROB_IDX_W]
src_res_in  input  NUM_SRC*WORD_W  flattened results
src_jump_en_in  input  NUM_SRC  per-source jump flag
src_jump_a_in  input  NUM_SRC*ADDR_W  flattened jump targets
cdb_en_out  output  1  CDB valid (registered)
cdb_src_out  output  2  index of winning source (registered)
cdb_rob_pos_out  output  ROB_IDX_W  winning ROB position
cdb_res_out  output  WORD_W  winning result
cdb_jump_en_out  output  1  winning jump flag
cdb_jump_a_out  output  ADDR_W  winning jump target

Behaviour:
- Reset (rst_n_in low at edge, regardless of rdy_in) sets:
  - buf_valid to all 0 and rr_ptr to 0.
  - cdb_en_out, cdb_src_out, cdb_rob_pos_out, cdb_res_out, cdb_jump_en_out and cdb_jump_a_out to 0.
- Reset dominates flush and rdy_in. Mid-operation reset drops all buffered results.
- State:
  - Per source i: buf_valid[i] and a buffered {rob_pos, res, jump_en, jump_a}.
  - rr_ptr (0..NUM_SRC-1).
  - Output registers.
- Grant (combinational, from registered state only):
  - Candidates are the sources with buf_valid set.
  - Winner = first candidate scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - grant is one-hot or zero.
- src_ready_out[i] = rdy_in && !clear_branch_in && (!buf_valid[i] || grant[i]). It has no combinational path from src_valid_in.
- Handshake: on an edge with src_valid_in[i] && src_ready_out[i], the source payload is written into buffer i and buf_valid[i] is set.
- Rising edge, rdy_in high, no flush:
  - If a grant exists:
    - Winner payload goes to the cdb_* registers and cdb_en_out is set to 1.
    - cdb_src_out is set to the winner index.
    - buf_valid[winner] is cleared, unless the same source is refilled that edge; refill wins and leaves it set with the new payload.
    - rr_ptr is set to (winner+1) mod NUM_SRC.
  - If no grant: cdb_en_out is set to 0, the other cdb_* registers hold, and rr_ptr holds.
- Latency: handshake accepted at edge t, with no contention, gives cdb_en_out high in the cycle after edge t+1.
- Throughput:
  - One result per cycle total.
  - A lone source sustains one result per cycle (grant-refill overlap).
- Fairness: a buffered result waits at most NUM_SRC-1 grants.
- rdy_in low: nothing changes, outputs hold their values (including cdb_en_out), and src_ready_out is all 0.
- clear_branch_in high with rdy_in high:
  - Sets buf_valid to all 0, cdb_en_out to 0 and rr_ptr to 0.
  - No grant is issued and no input is accepted that edge.
- Payload is passed unchanged; no width conversion. ROB position 0 is passed through without checking.
- Simultaneous valid from every source with all buffers empty: all are accepted the same edge, then drained over NUM_SRC cycles in rr order.

Decomposition:
- Shared config header (alongside the existing width macros) gains:
  - CDB source count and the source index constants SRC_ALU=0, SRC_BR=1, SRC_LSB=2.
  - CDBSrcWidth=2.
- One sub-module, cdb_rr_pick: combinational rotate-priority picker. Inputs are request vector and pointer; outputs are one-hot grant, winner index and any-grant.
- Buffers, handshake and output registers stay in cdb_arbiter.

Test Plan:
- Reset then idle: hold rst_n_in low 2 cycles, release with no valid -> all cdb_* = 0, src_ready_out = 3'b111.
- Single ALU result: src_valid_in=3'b001, rob_pos=5, res=32'hDEADBEEF, 1 cycle -> next-but-one cycle cdb_en_out=1, cdb_rob_pos_out=5, cdb_res_out=32'hDEADBEEF, cdb_src_out=0; cdb_en_out=0 the following cycle.
- Three-way contention: all valid 1 cycle, rob_pos 1/2/3 for src 0/1/2, rr_ptr=0 -> CDB shows pos 1, 2, 3 on consecutive cycles. Repeat with rr_ptr=2 -> order 3, 1, 2.
- Back-to-back lone source: LSB valid 4 consecutive cycles, pos 4..7 -> src_ready_out[2] stays 1 and CDB shows 4, 5, 6, 7 on consecutive cycles.
- Flush: buffer src0 (pos 6) and src1 (pos 7), assert clear_branch_in the cycle src0 is granted -> cdb_en_out=0 after the edge, no later CDB output, rr_ptr=0, and src_ready_out=0 during the flush cycle.
- rdy_in stall: with src1 buffered (pos 9, jump_en=1, jump_a=32'h100), drop rdy_in for 3 cycles -> no state change and src_ready_out=0. Raise rdy_in -> CDB shows pos 9, jump_en 1, jump_a 32'h100 one cycle later.
